// File: rtl/io_manager_param.sv
// I/O manager for the single-cycle RISC-V core: addressable display registers
// plus a stall/confirm handshake that delivers a debounced switch capture.
module io_manager_param #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned SW_W       = 16,
   parameter int unsigned N_OUT      = 2,
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned HOLD       = 1,
   parameter logic [DATA_W-1:0] IDLE_VAL  = DATA_W'(100),
   parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(170),
   localparam int unsigned SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DATA_W-1:0]       dado,
   input  logic                    RegToDisp,
   input  logic [SEL_W-1:0]        disp_sel,
   input  logic                    SwToReg,
   input  logic [SW_W-1:0]         switches,
   input  logic                    key,
   output logic [N_OUT*DATA_W-1:0] stdout,
   output logic [DATA_W-1:0]       dado_sw32,
   output logic                    in_valid,
   output logic                    stall
);

   localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Display channels; an out-of-range select matches no channel and is dropped.
   for (genvar i = 0; i < int'(N_OUT); i++) begin : g_ch
      localparam bit IDLE_LOAD = (HOLD == 0) && (i == 0);
      logic              wr_c;
      logic [DATA_W-1:0] ch_q;

      assign wr_c = RegToDisp && (disp_sel == SEL_W'(i));

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            ch_q <= RESET_VAL;
         end else if (wr_c) begin
            ch_q <= dado;
         end else if (IDLE_LOAD && !RegToDisp) begin
            ch_q <= IDLE_VAL;
         end
      end

      assign stdout[i*DATA_W +: DATA_W] = ch_q;
   end

   // Two-flop synchronisers for the asynchronous board inputs.
   logic [SW_W-1:0] sw_meta_q, sw_s_q;
   logic            key_meta_q, key_s_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_meta_q  <= '0;
         sw_s_q     <= '0;
         key_meta_q <= 1'b0;
         key_s_q    <= 1'b0;
      end else begin
         sw_meta_q  <= switches;
         sw_s_q     <= sw_meta_q;
         key_meta_q <= key;
         key_s_q    <= key_meta_q;
      end
   end

   // Debounce: key_s must disagree with key_stable for DEB_CYCLES samples in a row.
   logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
   logic             key_stable_q, key_stable_d;
   logic             key_stable_dly_q;
   logic             key_press_c;

   always_comb begin
      deb_cnt_d    = '0;
      key_stable_d = key_stable_q;
      if (key_s_q != key_stable_q) begin
         if (deb_cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            key_stable_d = key_s_q;
         end else begin
            deb_cnt_d = deb_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb_cnt_q        <= '0;
         key_stable_q     <= 1'b0;
         key_stable_dly_q <= 1'b0;
      end else begin
         deb_cnt_q        <= deb_cnt_d;
         key_stable_q     <= key_stable_d;
         key_stable_dly_q <= key_stable_q;
      end
   end

   assign key_press_c = key_stable_q & ~key_stable_dly_q;

   // Switch-read handshake FSM.
   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] cap_q, cap_d;

   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      stall   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            stall = SwToReg;
            if (SwToReg) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            stall = 1'b1;
            if (key_press_c) begin
               cap_d   = DATA_W'(sw_s_q);
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cap_q   <= '0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
      end
   end

   assign dado_sw32 = cap_q;
   assign in_valid  = (state_q == ST_DONE);

endmodule

// File: tb/tb_io_manager_param.sv
// Directed bench for io_manager_param: display writes, debounce, switch-read
// handshake; captures are checked by a scoreboard monitor on in_valid.
module tb_io_manager_param;

   typedef struct {
      logic [31:0] data;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] dado;
   logic        RegToDisp;
   logic [0:0]  disp_sel;
   logic        SwToReg;
   logic [15:0] switches;
   logic        key;
   logic [63:0] stdout;
   logic [31:0] dado_sw32;
   logic        in_valid;
   logic        stall;

   logic [31:0] d2_dado;
   logic        d2_reg;
   logic [1:0]  d2_sel;
   logic        d2_swtoreg;
   logic [15:0] d2_switches;
   logic        d2_key;
   logic [95:0] d2_stdout;
   logic [31:0] d2_sw32;
   logic        d2_in_valid;
   logic        d2_stall;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned cyc   = 0;
   exp_t        sb_q[$];

   io_manager_param dut (
      .clk(clk), .reset(reset), .dado(dado), .RegToDisp(RegToDisp),
      .disp_sel(disp_sel), .SwToReg(SwToReg), .switches(switches), .key(key),
      .stdout(stdout), .dado_sw32(dado_sw32), .in_valid(in_valid), .stall(stall)
   );

   io_manager_param #(.N_OUT(3), .HOLD(0)) dut2 (
      .clk(clk), .reset(reset), .dado(d2_dado), .RegToDisp(d2_reg),
      .disp_sel(d2_sel), .SwToReg(d2_swtoreg), .switches(d2_switches), .key(d2_key),
      .stdout(d2_stdout), .dado_sw32(d2_sw32), .in_valid(d2_in_valid), .stall(d2_stall)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Raise the key and book the capture expected 7 edges later.
   task automatic press(input logic [15:0] sw_exp);
      exp_t e;
      e.data = {16'h0, sw_exp};
      e.cyc  = cyc + 7;
      sb_q.push_back(e);
      key = 1'b1;
   endtask

   // Scoreboard monitor: every in_valid cycle must match a booked capture.
   always @(negedge clk) begin
      if (!reset && in_valid) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_in_valid", 64'(in_valid), 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("cap_data", 64'(dado_sw32), 64'(e.data));
            chk("cap_cycle", 64'(cyc), 64'(e.cyc));
            chk("cap_stall", 64'(stall), 64'd0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; dado = '0; RegToDisp = 1'b0; disp_sel = '0; SwToReg = 1'b0;
      switches = 16'hA5A5; key = 1'b0;
      d2_dado = '0; d2_reg = 1'b0; d2_sel = '0; d2_swtoreg = 1'b0;
      d2_switches = '0; d2_key = 1'b0;
      wait_neg(2);
      chk("rst_ch0", 64'(stdout[31:0]), 64'd170);
      chk("rst_ch1", 64'(stdout[63:32]), 64'd170);
      chk("rst_sw32", 64'(dado_sw32), 64'd0);
      chk("rst_valid", 64'(in_valid), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("d2_rst_ch0", 64'(d2_stdout[31:0]), 64'd170);
      reset = 1'b0;

      // Display writes; dut2 has HOLD=0 so its idle channel 0 reloads 100.
      RegToDisp = 1'b1; disp_sel = 1'b1; dado = 32'hDEADBEEF;
      wait_neg(1);
      RegToDisp = 1'b0;
      chk("wr_ch1", 64'(stdout[63:32]), 64'hDEADBEEF);
      chk("wr_ch0_hold", 64'(stdout[31:0]), 64'd170);
      chk("d2_idle_ch0", 64'(d2_stdout[31:0]), 64'd100);
      RegToDisp = 1'b1; disp_sel = 1'b0; dado = 32'h12345678;
      d2_reg = 1'b1; d2_sel = 2'd0; d2_dado = 32'h77;
      wait_neg(1);
      RegToDisp = 1'b0;
      chk("wr_ch0", 64'(stdout[31:0]), 64'h12345678);
      chk("wr_ch1_keep", 64'(stdout[63:32]), 64'hDEADBEEF);
      chk("d2_wr_ch0", 64'(d2_stdout[31:0]), 64'h77);
      d2_sel = 2'd2; d2_dado = 32'h55;
      wait_neg(1);
      chk("d2_wr_ch2", 64'(d2_stdout[95:64]), 64'h55);
      chk("d2_ch0_no_idle", 64'(d2_stdout[31:0]), 64'h77);
      d2_reg = 1'b0;
      wait_neg(3);
      chk("ch0_hold_idle", 64'(stdout[31:0]), 64'h12345678);
      chk("d2_ch0_idle", 64'(d2_stdout[31:0]), 64'd100);
      d2_reg = 1'b1; d2_sel = 2'd3; d2_dado = 32'h99;
      wait_neg(1);
      d2_reg = 1'b0;
      chk("d2_drop_ch0", 64'(d2_stdout[31:0]), 64'd100);
      chk("d2_drop_ch1", 64'(d2_stdout[63:32]), 64'd170);
      chk("d2_drop_ch2", 64'(d2_stdout[95:64]), 64'h55);

      // Basic handshake.
      SwToReg = 1'b1;
      #1 chk("idle_stall_comb", 64'(stall), 64'd1);
      wait_neg(1);
      SwToReg = 1'b0;
      chk("wait_stall", 64'(stall), 64'd1);
      press(16'hA5A5);
      wait_neg(6);
      chk("stall_before_done", 64'(stall), 64'd1);
      wait_neg(2);
      chk("valid_one_cycle", 64'(in_valid), 64'd0);
      chk("stall_after_done", 64'(stall), 64'd0);
      wait_neg(2);
      key = 1'b0;
      wait_neg(10);
      chk("sw32_holds", 64'(dado_sw32), 64'h0000A5A5);

      // Glitch shorter than the debounce window is ignored in WAIT.
      switches = 16'h0F0F;
      SwToReg = 1'b1;
      wait_neg(1);
      SwToReg = 1'b0;
      key = 1'b1;
      wait_neg(3);
      key = 1'b0;
      wait_neg(12);
      chk("glitch_stall", 64'(stall), 64'd1);
      chk("glitch_no_cap", 64'(dado_sw32), 64'h0000A5A5);
      press(16'h0F0F);
      wait_neg(10);
      key = 1'b0;
      wait_neg(10);

      // Key held before the request must be released and pressed again.
      switches = 16'h5A5A;
      key = 1'b1;
      wait_neg(10);
      SwToReg = 1'b1;
      wait_neg(1);
      SwToReg = 1'b0;
      wait_neg(8);
      chk("held_key_stall", 64'(stall), 64'd1);
      key = 1'b0;
      wait_neg(10);
      chk("release_stall", 64'(stall), 64'd1);
      chk("release_no_cap", 64'(dado_sw32), 64'h00000F0F);
      press(16'h5A5A);
      wait_neg(10);
      key = 1'b0;
      wait_neg(10);

      // Simultaneous display write and switch request, then reset mid-WAIT.
      RegToDisp = 1'b1; disp_sel = 1'b0; dado = 32'd7; SwToReg = 1'b1;
      #1 chk("sim_stall_comb", 64'(stall), 64'd1);
      wait_neg(1);
      RegToDisp = 1'b0; SwToReg = 1'b0;
      chk("sim_ch0", 64'(stdout[31:0]), 64'd7);
      chk("sim_wait", 64'(stall), 64'd1);
      wait_neg(1);
      reset = 1'b1;
      #1;
      chk("arst_stall", 64'(stall), 64'd0);
      chk("arst_ch0", 64'(stdout[31:0]), 64'd170);
      chk("arst_ch1", 64'(stdout[63:32]), 64'd170);
      chk("arst_sw32", 64'(dado_sw32), 64'd0);
      chk("arst_d2_ch2", 64'(d2_stdout[95:64]), 64'd170);
      wait_neg(1);
      reset = 1'b0;
      key = 1'b1;
      wait_neg(10);
      key = 1'b0;
      wait_neg(10);
      chk("noreq_sw32", 64'(dado_sw32), 64'd0);
      chk("noreq_stall", 64'(stall), 64'd0);

      // Back-to-back: request held through DONE re-enters WAIT.
      switches = 16'h3C3C;
      wait_neg(3);
      SwToReg = 1'b1;
      wait_neg(1);
      press(16'h3C3C);
      wait_neg(8);
      chk("b2b_idle_stall", 64'(stall), 64'd1);
      wait_neg(1);
      SwToReg = 1'b0;
      chk("b2b_wait_stall", 64'(stall), 64'd1);
      key = 1'b0;
      switches = 16'hC3C3;
      wait_neg(10);
      press(16'hC3C3);
      wait_neg(10);
      key = 1'b0;
      wait_neg(10);
      chk("b2b_final_sw32", 64'(dado_sw32), 64'h0000C3C3);
      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
